// File: rtl/qpi_psram_target.sv
// QPI PSRAM target model: oversampled QPI slave in front of a byte-wide synchronous RAM.
// Supports quad read (0xEB) with configurable dummy cycles and quad write (0x38).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | chip deselected, waiting for an ncs falling edge
// S_CMD    | shifting in the two command nibbles
// S_ADDR   | shifting in the six address nibbles
// S_DUMMY  | counting wait cycles before read data
// S_RDATA  | driving read nibbles on sclk falling edges
// S_WDATA  | capturing write nibbles, one byte per two rising edges
// S_IGNORE | unsupported command, idle until ncs deasserts
module qpi_psram_target #(
    parameter int ADDR_BITS    = 12,
    parameter int DUMMY_CYCLES = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       qpi_sclk,
    input  logic       qpi_ncs,
    input  logic [3:0] qpi_sin,
    output logic [3:0] qpi_sout,
    output logic       qpi_oe,
    output logic       busy,
    output logic       cmd_err
);

    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam logic [7:0] DUMMY_LAST = (DUMMY_CYCLES == 0) ? 8'd0 : 8'(DUMMY_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RDATA,
        S_WDATA,
        S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [3:0]             r_sin_sync [SYNC_STAGES];
    logic                   r_sclk_d;
    logic                   r_ncs_d;

    logic                   w_sclk;
    logic                   w_ncs;
    logic [3:0]             w_sin;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_ncs_fall;

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_cnt;
    logic                   r_phase;
    logic [7:0]             r_cmd;
    logic [7:0]             w_cmd_full;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [7:0]             r_wbyte;
    logic                   r_wr_pend;
    logic [3:0]             r_sout;
    logic                   r_oe;
    logic                   r_cmd_err;

    logic [7:0]             r_mem [0:(1<<ADDR_BITS)-1];
    logic [7:0]             r_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_sin_sync[i] <= 4'h0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_sclk_sync[0] <= qpi_sclk;
            r_ncs_sync[0]  <= qpi_ncs;
            r_sin_sync[0]  <= qpi_sin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_ncs_sync[i]  <= r_ncs_sync[i-1];
                r_sin_sync[i]  <= r_sin_sync[i-1];
            end
            r_sclk_d <= w_sclk;
            r_ncs_d  <= w_ncs;
        end
    end

    // ncs synchronizer resets low, so a select held across reset never looks like a new edge
    assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs      = r_ncs_sync[SYNC_STAGES-1];
    assign w_sin      = r_sin_sync[SYNC_STAGES-1];
    assign w_rise     = w_sclk & ~r_sclk_d;
    assign w_fall     = ~w_sclk & r_sclk_d;
    assign w_ncs_fall = ~w_ncs & r_ncs_d;
    assign w_cmd_full = {r_cmd[3:0], w_sin};

    always_comb begin
        w_next = r_state;
        if (w_ncs) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:   if (w_ncs_fall) w_next = S_CMD;
                S_CMD: begin
                    if (w_rise && r_cnt == 8'd1) begin
                        if (w_cmd_full == CMD_READ || w_cmd_full == CMD_WRITE) w_next = S_ADDR;
                        else w_next = S_IGNORE;
                    end
                end
                S_ADDR: begin
                    if (w_rise && r_cnt == 8'd5) begin
                        if (r_cmd == CMD_READ) w_next = (DUMMY_CYCLES == 0) ? S_RDATA : S_DUMMY;
                        else w_next = S_WDATA;
                    end
                end
                S_DUMMY:  if (w_rise && r_cnt == DUMMY_LAST) w_next = S_RDATA;
                S_RDATA:  w_next = S_RDATA;
                S_WDATA:  w_next = S_WDATA;
                S_IGNORE: w_next = S_IGNORE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_phase   <= 1'b0;
            r_cmd     <= 8'd0;
            r_addr    <= '0;
            r_wbyte   <= 8'd0;
            r_wr_pend <= 1'b0;
            r_sout    <= 4'h0;
            r_oe      <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cmd_err <= (r_state == S_CMD) && (w_next == S_IGNORE);
            r_wr_pend <= 1'b0;
            r_oe      <= (w_next == S_RDATA) && (r_oe || (r_state == S_RDATA && w_fall));

            if (w_next != r_state) begin
                r_cnt   <= 8'd0;
                r_phase <= 1'b0;
            end else if (w_rise && (r_state == S_CMD || r_state == S_ADDR || r_state == S_DUMMY)) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_state == S_CMD && w_rise && !w_ncs)
                r_cmd <= w_cmd_full;

            if (r_state == S_ADDR && w_rise && !w_ncs)
                r_addr <= (r_addr << 4) | {{(ADDR_BITS-4){1'b0}}, w_sin};

            // read data was fetched from r_addr well before this edge
            if (r_state == S_RDATA && w_fall && !w_ncs) begin
                r_sout  <= r_phase ? r_rdata[3:0] : r_rdata[7:4];
                r_phase <= ~r_phase;
                if (r_phase) r_addr <= r_addr + ADDR_ONE;
            end

            if (r_state == S_WDATA && w_rise && !w_ncs) begin
                if (!r_phase) begin
                    r_wbyte[7:4] <= w_sin;
                end else begin
                    r_wbyte[3:0] <= w_sin;
                    r_wr_pend    <= 1'b1;
                end
                r_phase <= ~r_phase;
            end

            if (r_wr_pend) r_addr <= r_addr + ADDR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (r_wr_pend) r_mem[r_addr] <= r_wbyte;
        r_rdata <= r_mem[r_addr];
    end

    assign qpi_sout = r_sout;
    assign qpi_oe   = r_oe;
    assign busy     = (r_state != S_IDLE);
    assign cmd_err  = r_cmd_err;

endmodule
